// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core.
//   ADDR_W / INSTR_W : default address and instruction widths
//   state_e          : fetch FSM state encoding
//   sext8            : 8-bit to ADDR_W sign extension (branch offsets, ALU immediates)
package cpu_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] sext8(input logic [7:0] v);
    return {{(ADDR_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
//   pc_i         : current PC
//   off_i        : instr[7:0], signed branch displacement
//   jmp_i        : take jmp_target_i (highest priority)
//   branch_i     : take pc + sext(off_i)
//   jmp_target_i : register-file jump target
//   next_pc_o    : selected next PC (jmp > branch > pc+1)
//   link_pc_o    : pc+1, return address for JAL
// All arithmetic wraps modulo 2^ADDR_W.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = cpu_pkg::ADDR_W
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [7:0]      off_i,
  input  logic            jmp_i,
  input  logic            branch_i,
  input  logic [PC_W-1:0] jmp_target_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic [PC_W-1:0] link_pc_o
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_pc;

  // Signed resize keeps the displacement correct for any PC width.
  assign seq_pc    = pc_i + PC_W'(1);
  assign br_pc     = pc_i + PC_W'($signed(sext8(off_i)));
  assign link_pc_o = seq_pc;

  always_comb begin
    next_pc_o = seq_pc;
    if (jmp_i)         next_pc_o = jmp_target_i;
    else if (branch_i) next_pc_o = br_pc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack handshake, instruction
// register and next-PC update from decode.
//   clk, reset              : clock, synchronous active-high reset
//   imem_req/addr/ack/rdata : instruction memory handshake
//   instr, instr_valid      : instruction register to decode, valid in EXEC
//   stall, jmp, branch,
//   jmp_target              : control from decode, honoured only in EXEC
//   pc, link_pc             : current PC and pc+1
//   fetch_err               : sticky fetch timeout flag
// Optional macro FETCH_TIMEOUT_EN: abort a fetch after TIMEOUT_CYC cycles
// without ack, set fetch_err and park in HALT until reset.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_W      = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter int unsigned          TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              jmp,
  input  logic              branch,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic              fetch_err
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q;

  next_pc_calc #(.PC_W(ADDR_W)) u_npc (
    .pc_i         (pc_q),
    .off_i        (instr_q[7:0]),
    .jmp_i        (jmp),
    .branch_i     (branch),
    .jmp_target_i (jmp_target),
    .next_pc_o    (pc_d),
    .link_pc_o    (link_pc)
  );

  // Gated by reset so nothing is requested or presented in a reset cycle,
  // whatever state the register held before it.
  assign imem_req    = (state_q == FETCH) && !reset;
  assign instr_valid = (state_q == EXEC)  && !reset;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             err_q;

  assign wait_d    = wait_q + CNT_W'(1);
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= EXEC;
`ifdef FETCH_TIMEOUT_EN
            wait_q  <= '0;
          end else if (wait_d == CNT_W'(TIMEOUT_CYC)) begin
            err_q   <= 1'b1;
            state_q <= HALT;
          end else begin
            wait_q  <= wait_d;
`endif
          end
        end
        EXEC: begin
          if (!stall) begin
            pc_q    <= pc_d;
            state_q <= FETCH;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        HALT: state_q <= HALT;
`endif
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        jmp;
  logic        branch;
  logic [15:0] jmp_target;
  logic [15:0] pc;
  logic [15:0] link_pc;
  logic        fetch_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .jmp(jmp), .branch(branch), .jmp_target(jmp_target),
    .pc(pc), .link_pc(link_pc), .fetch_err(fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Complete a fetch with a same-cycle ack, leaving the FSM in EXEC.
  task automatic fetch_now(input logic [15:0] addr, input logic [15:0] word, input string tag);
    chk({tag, "_req"},  32'(imem_req), 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0; imem_rdata = 16'hDEAD;
    chk({tag, "_instr"}, 32'(instr), 32'(word));
    chk({tag, "_ival"},  32'(instr_valid), 32'd1);
  endtask

  // One unstalled EXEC cycle with the given decode controls.
  task automatic exec_now(input logic j, input logic b, input logic [15:0] tgt);
    jmp = j; branch = b; jmp_target = tgt;
    step();
    jmp = 1'b0; branch = 1'b0; jmp_target = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;
    stall = 1'b0; jmp = 1'b0; branch = 1'b0; jmp_target = 16'h0000;
    step(); step();
    chk("rst_pc",    32'(pc), 32'h0000);
    chk("rst_instr", 32'(instr), 32'h0000);
    chk("rst_ival",  32'(instr_valid), 32'd0);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_err",   32'(fetch_err), 32'd0);

    // Single-cycle fetch, then sequential advance.
    reset = 1'b0;
    #1;
    fetch_now(16'h0000, 16'h0123, "f0");
    chk("f0_reqlow", 32'(imem_req), 32'd0);
    chk("f0_link",   32'(link_pc), 32'h0001);
    exec_now(1'b0, 1'b0, 16'h0000);
    chk("seq_pc",  32'(pc), 32'h0001);
    chk("seq_req", 32'(imem_req), 32'd1);

    // Ack delayed by three cycles: request and address held, no valid.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dly_req",  32'(imem_req), 32'd1);
      chk("dly_addr", 32'(imem_addr), 32'h0001);
      chk("dly_ival", 32'(instr_valid), 32'd0);
    end
    fetch_now(16'h0001, 16'h1111, "f1");
    exec_now(1'b1, 1'b0, 16'h0010);
    chk("jmp_pc", 32'(pc), 32'h0010);

    // Backward branch: 0x10 + sext(0xFC) = 0x0C.
    fetch_now(16'h0010, 16'h20FC, "f2");
    exec_now(1'b0, 1'b1, 16'h5555);
    chk("br_pc", 32'(pc), 32'h000C);

    // Sequential wrap from 0xFFFF.
    fetch_now(16'h000C, 16'h0000, "f3");
    exec_now(1'b1, 1'b0, 16'hFFFF);
    fetch_now(16'hFFFF, 16'h0000, "f4");
    chk("wrap_link", 32'(link_pc), 32'h0000);
    exec_now(1'b0, 1'b0, 16'h0000);
    chk("wrap_pc", 32'(pc), 32'h0000);

    // jmp and branch together: jmp wins; link_pc is old pc + 1.
    fetch_now(16'h0000, 16'h0005, "f5");
    chk("jb_link", 32'(link_pc), 32'h0001);
    exec_now(1'b1, 1'b1, 16'h0200);
    chk("jb_pc", 32'(pc), 32'h0200);

    // Stall four cycles in EXEC, with a jmp pending that must not apply yet.
    fetch_now(16'h0200, 16'hABCD, "f6");
    stall = 1'b1; jmp = 1'b1; jmp_target = 16'h9999;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stl_instr", 32'(instr), 32'hABCD);
      chk("stl_pc",    32'(pc), 32'h0200);
      chk("stl_ival",  32'(instr_valid), 32'd1);
    end
    stall = 1'b0; jmp = 1'b0;
    step();
    chk("unstl_pc",  32'(pc), 32'h0201);
    chk("unstl_req", 32'(imem_req), 32'd1);

    // Decode controls in FETCH are ignored.
    jmp = 1'b1; branch = 1'b1; jmp_target = 16'h7777;
    step();
    jmp = 1'b0; branch = 1'b0;
    chk("fjmp_pc",  32'(pc), 32'h0201);
    chk("fjmp_req", 32'(imem_req), 32'd1);

    // Reset mid-FETCH, with an ack arriving in the reset cycle itself.
    reset = 1'b1;
    step();
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    #1;
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_pc",  32'(pc), 32'h0000);
    step();
    imem_ack = 1'b0; reset = 1'b0;
    #1;
    chk("mrst_instr", 32'(instr), 32'h0000);
    chk("mrst_ival",  32'(instr_valid), 32'd0);
    chk("mrst_refetch", 32'(imem_req), 32'd1);
    chk("mrst_addr",  32'(imem_addr), 32'h0000);

`ifdef FETCH_TIMEOUT_EN
    // No ack: four FETCH cycles then HALT with sticky error.
    for (int i = 0; i < 3; i++) step();
    chk("to_pre_err", 32'(fetch_err), 32'd0);
    step();
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    step(); step();
    imem_ack = 1'b0;
    chk("halt_req",  32'(imem_req), 32'd0);
    chk("halt_ival", 32'(instr_valid), 32'd0);
    chk("halt_err",  32'(fetch_err), 32'd1);
`else
    // Without the timeout the fetch waits indefinitely and never flags.
    for (int i = 0; i < 10; i++) step();
    chk("nto_req", 32'(imem_req), 32'd1);
    chk("nto_err", 32'(fetch_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
